// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory arbiter.
// Size codes, FSM states, and the access legality check.
package dmem_pkg;

    localparam logic [2:0] SZ_B  = 3'b000;
    localparam logic [2:0] SZ_H  = 3'b001;
    localparam logic [2:0] SZ_W  = 3'b010;
    localparam logic [2:0] SZ_BU = 3'b100;
    localparam logic [2:0] SZ_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_e;

    // Zero marks an illegal size code.
    function automatic logic [2:0] size_bytes(input logic [2:0] size);
        case (size)
            SZ_B, SZ_BU: size_bytes = 3'd1;
            SZ_H, SZ_HU: size_bytes = 3'd2;
            SZ_W:        size_bytes = 3'd4;
            default:     size_bytes = 3'd0;
        endcase
    endfunction

    function automatic logic access_err(
        input logic        we,
        input logic [2:0]  size,
        input logic [31:0] addr,
        input logic [31:0] mem_bytes
    );
        logic [2:0]  n;
        logic [32:0] last;
        logic [32:0] top;
        n    = size_bytes(size);
        last = {1'b0, addr} + {30'b0, n} - 33'd1;
        top  = {1'b0, mem_bytes} - 33'd1;
        access_err = (n == 3'd0)
                   || (we && size[2])
                   || (((size == SZ_H) || (size == SZ_HU)) && addr[0])
                   || ((size == SZ_W) && (addr[1:0] != 2'b00))
                   || (last > top);
    endfunction

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-requester round-robin grant logic.
// The side that did not win last time takes a contended cycle.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       en,
    input  logic       last_grant,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = 2'b00;
        if (en) begin
            unique case (req)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                2'b11:   gnt = last_grant ? 2'b01 : 2'b10;
                default: gnt = 2'b00;
            endcase
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin sequencer sharing the data memory between two requesters.
// One access per two cycles: accept, memory cycle, registered response.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int ADDR_W    = 12,
    parameter int DATA_W    = 32,
    parameter int MEM_BYTES = 4096
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [1:0]            req_valid,
    output logic [1:0]            req_ready,
    input  logic [1:0]            req_we,
    input  logic [5:0]            req_size,
    input  logic [2*ADDR_W-1:0]   req_addr,
    input  logic [2*DATA_W-1:0]   req_wdata,
    output logic [1:0]            rsp_valid,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic                  rsp_err,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic [2:0]            mem_byte_select,
    input  logic [DATA_W-1:0]     mem_rdata
);

    state_e              state_q, state_d;
    logic                port_q, port_d;
    logic                we_q, we_d;
    logic [2:0]          size_q, size_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                err_q, err_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                last_grant_q, last_grant_d;

    logic [1:0]          gnt;
    logic                en;
    logic                accept;
    logic                sel;
    logic                sel_we;
    logic [2:0]          sel_size;
    logic [ADDR_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   sel_wdata;
    logic                in_acc;
    logic                in_rsp;

    // Nothing is accepted while the memory cycle is in flight.
    assign en = rst_n && (state_q != ACCESS);

    rr_arb2 u_arb (
        .req        (req_valid),
        .en         (en),
        .last_grant (last_grant_q),
        .gnt        (gnt)
    );

    assign req_ready = gnt;
    assign accept    = |gnt;
    assign sel       = gnt[1];
    assign sel_we    = sel ? req_we[1] : req_we[0];
    assign sel_size  = sel ? req_size[5:3] : req_size[2:0];
    assign sel_addr  = sel ? req_addr[2*ADDR_W-1:ADDR_W]
                           : req_addr[ADDR_W-1:0];
    assign sel_wdata = sel ? req_wdata[2*DATA_W-1:DATA_W]
                           : req_wdata[DATA_W-1:0];

    always_comb begin
        state_d      = state_q;
        port_d       = port_q;
        we_d         = we_q;
        size_d       = size_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        err_d        = err_q;
        rdata_d      = rdata_q;
        last_grant_d = last_grant_q;
        unique case (state_q)
            IDLE, RESP: state_d = accept ? ACCESS : IDLE;
            ACCESS: begin
                state_d = RESP;
                rdata_d = (we_q || err_q) ? '0 : mem_rdata;
            end
            default: state_d = IDLE;
        endcase
        if (accept) begin
            port_d       = sel;
            we_d         = sel_we;
            size_d       = sel_size;
            addr_d       = sel_addr;
            wdata_d      = sel_wdata;
            err_d        = access_err(sel_we, sel_size, 32'(sel_addr),
                                      32'(MEM_BYTES));
            last_grant_d = sel;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            port_q       <= 1'b0;
            we_q         <= 1'b0;
            size_q       <= 3'b000;
            addr_q       <= '0;
            wdata_q      <= '0;
            err_q        <= 1'b0;
            rdata_q      <= '0;
            last_grant_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            port_q       <= port_d;
            we_q         <= we_d;
            size_q       <= size_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            err_q        <= err_d;
            rdata_q      <= rdata_d;
            last_grant_q <= last_grant_d;
        end
    end

    // Decoded from the state flop so reset kills a write at once.
    assign in_acc = (state_q == ACCESS);
    assign in_rsp = (state_q == RESP);

    assign mem_read        = in_acc && !we_q && !err_q;
    assign mem_write       = in_acc && we_q && !err_q;
    assign mem_addr        = in_acc ? addr_q : '0;
    assign mem_wdata       = in_acc ? wdata_q : '0;
    assign mem_byte_select = in_acc ? size_q : 3'b000;

    assign rsp_valid = in_rsp ? (port_q ? 2'b10 : 2'b01) : 2'b00;
    assign rsp_rdata = in_rsp ? rdata_q : '0;
    assign rsp_err   = in_rsp && err_q;

endmodule
